axi_err_slv: RTL and testbench
==============================

Name: axi_err_slv

Overview:
- AXI4 default responder on the SoC crossbar's error/default master port.
- Every access that decodes to no slave in the SoC address map is routed here.
- Completes each such transaction protocol-correctly with DECERR, so the initiating master (CVA6, debug module, cluster) never hangs.
- Read and write channels are independent; each has one transaction in flight at a time.

Parameters:
- IdWidth, 7, AXI ID width seen on crossbar master side (5 + log2 of 4 crossbar slave ports).
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width.
- RespData, 64'hCA11_AB1E_BADC_AB1E, constant driven on rdata for every read beat.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- aw_id_i  in  IdWidth  write address ID.
- aw_addr_i  in  AddrWidth  write address.
- aw_valid_i  in  1 ; aw_ready_o  out  1
- w_last_i  in  1  last write beat.
- w_valid_i  in  1 ; w_ready_o  out  1
- b_id_o  out  IdWidth ; b_resp_o  out  2 ; b_valid_o  out  1 ; b_ready_i  in  1
- ar_id_i  in  IdWidth ; ar_addr_i  in  AddrWidth ; ar_len_i  in  8 ; ar_valid_i  in  1 ; ar_ready_o  out  1
- r_id_o  out  IdWidth ; r_data_o  out  DataWidth ; r_resp_o  out  2 ; r_last_o  out  1 ; r_valid_o  out  1 ; r_ready_i  in  1

Behaviour:
- Interface: one clock, clk_i; reset rst_ni, asynchronous, active-low.
- Reset values:
  - Both FSMs go to IDLE; captured IDs and beat counter clear to 0.
  - aw_ready_o=1, ar_ready_o=1.
  - w_ready_o=0, b_valid_o=0, r_valid_o=0, r_last_o=0.
  - b_resp_o=r_resp_o=2'b11; r_data_o=RespData.
- Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
  - W_IDLE: aw_ready_o=1, w_ready_o=0. On aw_valid_i, capture aw_id_i and go to W_DATA.
  - W_DATA: aw_ready_o=0, w_ready_o=1. Each W beat is discarded. A beat with w_last_i=1 moves the FSM to W_RESP. awlen is not checked; only w_last_i ends the burst.
  - W_RESP: b_valid_o=1, b_id_o=captured ID, b_resp_o=2'b11. On b_ready_i, return to W_IDLE.
  - Minimum write occupancy: AW cycle, one cycle per beat, B cycle. No combinational path from aw_valid_i to w_ready_o.
  - W beats presented before AW are stalled (w_ready_o=0), never dropped.
- Read FSM (R_IDLE -> R_DATA -> R_IDLE):
  - R_IDLE: ar_ready_o=1. On ar_valid_i, capture ar_id_i and ar_len_i, clear the 8-bit beat counter, go to R_DATA.
  - R_DATA: r_valid_o=1, r_id_o=captured ID, r_data_o=RespData, r_resp_o=2'b11.
  - r_last_o=1 only while beat counter == captured len.
  - Each r_valid_o & r_ready_i increments the counter.
  - Handshake with r_last_o=1 returns the FSM to R_IDLE.
  - len=255 gives 256 beats; the counter never wraps inside a burst.
- Outputs hold stable while valid & !ready (AXI stability rule).
- B and R are registered; first R beat appears the cycle after AR acceptance.
- AW and AR accepted in the same cycle are handled fully in parallel.
- Reset asserted mid-burst: both FSMs return to IDLE immediately; any partially returned burst is abandoned.

Optional Feature:
- Macro: AXI_ERR_SLV_LOG_EN.
- When defined, adds the following ports:
  - err_addr_o  out  AddrWidth: address of the most recent accepted AW or AR.
  - err_is_write_o  out  1: 1 if that access was a write.
  - err_cnt_o  out  16: count of accepted AW+AR, saturating at 16'hFFFF.
- Same-cycle AW and AR acceptance: err_addr_o takes aw_addr_i, err_is_write_o=1, err_cnt_o increments by 2 (saturating).
- All logging ports reset to 0.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- AW id=7'h12, single W beat with last=1, b_ready=1 -> one B with b_id=7'h12, b_resp=2'b11; aw_ready returns high next cycle.
- AR id=7'h05, len=3, r_ready=1 -> 4 R beats of 64'hCA11AB1EBADCAB1E, resp=2'b11, r_last only on 4th beat, id=7'h05.
- AR len=255 with r_ready toggling every other cycle -> exactly 256 beats, outputs stable during stalls, last on beat 256.
- Simultaneous AW id=1 / AR id=2 len=0 -> B id=1 and single-beat R id=2 both complete; with AXI_ERR_SLV_LOG_EN, err_cnt=2, err_is_write=1, err_addr=AW address.
- W beats asserted 3 cycles before AW -> w_ready stays 0 until AW accepted; no beat lost; B follows w_last.
- rst_ni asserted during beat 2 of a len=7 read -> r_valid drops immediately; after release, ar_ready=1 and a new AR completes normally.

Source files
------------

// File: rtl/axi_err_slv.sv
// AXI4 default responder: completes every unmapped access with DECERR.
// Optional access logging enabled by defining AXI_ERR_SLV_LOG_EN.
//
// state  | meaning
// W_IDLE | waiting for AW
// W_DATA | sinking W beats until w_last_i
// W_RESP | presenting B until b_ready_i
// R_IDLE | waiting for AR
// R_DATA | returning len+1 DECERR beats
module axi_err_slv #(
  parameter int unsigned IdWidth   = 7,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData = 64'hCA11_AB1E_BADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic                 w_last_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i
`ifdef AXI_ERR_SLV_LOG_EN
  ,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_is_write_o,
  output logic [15:0]          err_cnt_o
`endif
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t   w_state;
  r_state_t   r_state;
  logic [7:0] r_len;
  logic [7:0] beat_cnt;
  logic [7:0] beat_cnt_nxt;

  assign b_resp_o     = 2'b11;
  assign r_resp_o     = 2'b11;
  assign r_data_o     = RespData;
  assign beat_cnt_nxt = beat_cnt + 8'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state    <= W_IDLE;
      aw_ready_o <= 1'b1;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      b_id_o     <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_valid_i) begin
          b_id_o     <= aw_id_i;
          aw_ready_o <= 1'b0;
          w_ready_o  <= 1'b1;
          w_state    <= W_DATA;
        end
        W_DATA: if (w_valid_i && w_last_i) begin
          w_ready_o <= 1'b0;
          b_valid_o <= 1'b1;
          w_state   <= W_RESP;
        end
        W_RESP: if (b_ready_i) begin
          b_valid_o  <= 1'b0;
          aw_ready_o <= 1'b1;
          w_state    <= W_IDLE;
        end
        default: begin
          aw_ready_o <= 1'b1;
          w_ready_o  <= 1'b0;
          b_valid_o  <= 1'b0;
          w_state    <= W_IDLE;
        end
      endcase
    end
  end

  // r_last_o is precomputed one beat ahead so it stays a plain register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= R_IDLE;
      ar_ready_o <= 1'b1;
      r_valid_o  <= 1'b0;
      r_last_o   <= 1'b0;
      r_id_o     <= '0;
      r_len      <= '0;
      beat_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_valid_i) begin
          r_id_o     <= ar_id_i;
          r_len      <= ar_len_i;
          beat_cnt   <= '0;
          ar_ready_o <= 1'b0;
          r_valid_o  <= 1'b1;
          r_last_o   <= (ar_len_i == 8'd0);
          r_state    <= R_DATA;
        end
        R_DATA: if (r_ready_i) begin
          if (r_last_o) begin
            r_valid_o  <= 1'b0;
            r_last_o   <= 1'b0;
            ar_ready_o <= 1'b1;
            r_state    <= R_IDLE;
          end else begin
            beat_cnt <= beat_cnt_nxt;
            r_last_o <= (beat_cnt_nxt == r_len);
          end
        end
        default: begin
          ar_ready_o <= 1'b1;
          r_valid_o  <= 1'b0;
          r_last_o   <= 1'b0;
          r_state    <= R_IDLE;
        end
      endcase
    end
  end

`ifdef AXI_ERR_SLV_LOG_EN
  logic        aw_acc;
  logic        ar_acc;
  logic [16:0] cnt_sum;

  assign aw_acc  = aw_ready_o & aw_valid_i;
  assign ar_acc  = ar_ready_o & ar_valid_i;
  assign cnt_sum = {1'b0, err_cnt_o} + {16'd0, aw_acc} + {16'd0, ar_acc};

  // A simultaneous AW wins the address/direction log.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_addr_o     <= '0;
      err_is_write_o <= 1'b0;
      err_cnt_o      <= '0;
    end else begin
      if (aw_acc) begin
        err_addr_o     <= aw_addr_i;
        err_is_write_o <= 1'b1;
      end else if (ar_acc) begin
        err_addr_o     <= ar_addr_i;
        err_is_write_o <= 1'b0;
      end
      err_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_axi_err_slv.sv
// Directed self-checking bench for axi_err_slv (logging checks when AXI_ERR_SLV_LOG_EN is defined).
module tb_axi_err_slv;
  localparam logic [63:0] RESP = 64'hCA11_AB1E_BADC_AB1E;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  aw_id, ar_id, b_id, r_id;
  logic [63:0] aw_addr, ar_addr, r_data;
  logic [7:0]  ar_len;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready;
  logic [1:0]  b_resp, r_resp;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_last, r_valid, r_ready;
`ifdef AXI_ERR_SLV_LOG_EN
  logic [63:0] err_addr;
  logic        err_is_write;
  logic [15:0] err_cnt;
  logic [15:0] cnt_before;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi_err_slv dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_valid_i(ar_valid),
    .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_valid_o(r_valid), .r_ready_i(r_ready)
`ifdef AXI_ERR_SLV_LOG_EN
    , .err_addr_o(err_addr), .err_is_write_o(err_is_write), .err_cnt_o(err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats, cyc, last_bad, stab_bad;
    logic last_s;
    logic [6:0] id_s;

    rst_n = 1'b0;
    aw_id = '0; aw_addr = '0; aw_valid = 0; w_last = 0; w_valid = 0; b_ready = 0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 0; r_ready = 0;
    #12;
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_b_resp", b_resp, 2'b11);
    chk("rst_r_resp", r_resp, 2'b11);
    chk("rst_r_data", r_data, RESP);
`ifdef AXI_ERR_SLV_LOG_EN
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_is_write", err_is_write, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // single-beat write
    aw_id = 7'h12; aw_addr = 64'h1000; aw_valid = 1;
    tick();
    aw_valid = 0;
    chk("wr1_aw_ready_low", aw_ready, 0);
    chk("wr1_w_ready", w_ready, 1);
    w_valid = 1; w_last = 1;
    tick();
    w_valid = 0; w_last = 0;
    chk("wr1_b_valid", b_valid, 1);
    chk("wr1_b_id", b_id, 7'h12);
    chk("wr1_b_resp", b_resp, 2'b11);
    chk("wr1_w_ready_low", w_ready, 0);
    b_ready = 1;
    tick();
    b_ready = 0;
    chk("wr1_b_done", b_valid, 0);
    chk("wr1_aw_ready_back", aw_ready, 1);

    // 4-beat read
    ar_id = 7'h05; ar_addr = 64'h2000; ar_len = 8'd3; ar_valid = 1; r_ready = 1;
    tick();
    ar_valid = 0;
    chk("rd4_ar_ready_low", ar_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd4_valid_%0d", i), r_valid, 1);
      chk($sformatf("rd4_id_%0d", i), r_id, 7'h05);
      chk($sformatf("rd4_data_%0d", i), r_data, RESP);
      chk($sformatf("rd4_resp_%0d", i), r_resp, 2'b11);
      chk($sformatf("rd4_last_%0d", i), r_last, (i == 3) ? 1 : 0);
      tick();
    end
    r_ready = 0;
    chk("rd4_done", r_valid, 0);
    chk("rd4_ar_ready_back", ar_ready, 1);

    // 256-beat read with r_ready toggling
    ar_id = 7'h33; ar_addr = 64'h3000; ar_len = 8'd255; ar_valid = 1;
    tick();
    ar_valid = 0;
    beats = 0; cyc = 0; last_bad = 0; stab_bad = 0;
    while (r_valid && cyc < 1000) begin
      r_ready = cyc[0];
      if (r_last !== (beats == 255)) last_bad++;
      last_s = r_last;
      id_s = r_id;
      tick();
      if (r_ready) beats++;
      else if (r_valid !== 1'b1 || r_last !== last_s || r_id !== id_s) stab_bad++;
      cyc++;
    end
    r_ready = 0;
    chk("rd256_beats", beats, 256);
    chk("rd256_last_pos_errs", last_bad, 0);
    chk("rd256_stall_errs", stab_bad, 0);
    chk("rd256_cycles", cyc, 512);

    // simultaneous AW and AR
`ifdef AXI_ERR_SLV_LOG_EN
    cnt_before = err_cnt;
`endif
    aw_id = 7'h01; aw_addr = 64'hDEAD_0000_0000_1000; aw_valid = 1;
    ar_id = 7'h02; ar_addr = 64'hBEEF_0000_0000_2000; ar_len = 8'd0; ar_valid = 1;
    tick();
    aw_valid = 0; ar_valid = 0;
    chk("par_w_ready", w_ready, 1);
    chk("par_r_valid", r_valid, 1);
    chk("par_r_last", r_last, 1);
    chk("par_r_id", r_id, 7'h02);
`ifdef AXI_ERR_SLV_LOG_EN
    chk("par_err_cnt_delta", err_cnt - cnt_before, 2);
    chk("par_err_is_write", err_is_write, 1);
    chk("par_err_addr", err_addr, 64'hDEAD_0000_0000_1000);
`endif
    w_valid = 1; w_last = 1; r_ready = 1; b_ready = 1;
    tick();
    w_valid = 0; w_last = 0; r_ready = 0;
    chk("par_r_done", r_valid, 0);
    chk("par_b_valid", b_valid, 1);
    chk("par_b_id", b_id, 7'h01);
    tick();
    b_ready = 0;
    chk("par_b_done", b_valid, 0);
    chk("par_aw_ready", aw_ready, 1);
    chk("par_ar_ready", ar_ready, 1);

    // W presented before AW
    w_valid = 1; w_last = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("early_w_stalled_%0d", i), w_ready, 0);
    end
    aw_id = 7'h09; aw_valid = 1;
    tick();
    aw_valid = 0;
    chk("early_w_ready", w_ready, 1);
    tick();
    chk("early_no_b_yet", b_valid, 0);
    chk("early_w_ready_hold", w_ready, 1);
    w_last = 1;
    tick();
    w_valid = 0; w_last = 0;
    chk("early_b_valid", b_valid, 1);
    chk("early_b_id", b_id, 7'h09);
    b_ready = 1;
    tick();
    b_ready = 0;
    chk("early_b_done", b_valid, 0);

    // reset during a len=7 read
    ar_id = 7'h04; ar_addr = 64'h4000; ar_len = 8'd7; ar_valid = 1; r_ready = 1;
    tick();
    ar_valid = 0;
    tick();
    chk("rst_mid_beat2_valid", r_valid, 1);
    chk("rst_mid_beat2_last", r_last, 0);
    rst_n = 0;
    #1;
    chk("rst_mid_r_valid_drop", r_valid, 0);
    chk("rst_mid_ar_ready", ar_ready, 1);
    r_ready = 0;
    tick();
    rst_n = 1;
    tick();
    ar_id = 7'h06; ar_addr = 64'h5000; ar_len = 8'd1; ar_valid = 1; r_ready = 1;
    tick();
    ar_valid = 0;
    chk("post_rst_id", r_id, 7'h06);
    chk("post_rst_last0", r_last, 0);
    tick();
    chk("post_rst_last1", r_last, 1);
    chk("post_rst_valid1", r_valid, 1);
`ifdef AXI_ERR_SLV_LOG_EN
    chk("post_rst_err_cnt", err_cnt, 1);
    chk("post_rst_err_is_write", err_is_write, 0);
    chk("post_rst_err_addr", err_addr, 64'h5000);
`endif
    tick();
    r_ready = 0;
    chk("post_rst_done", r_valid, 0);
    chk("post_rst_ar_ready", ar_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
